// File: rtl/restore_div.sv
// restore_div: iterative restoring divider producing one quotient bit per clock
module restore_div #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd, r_q;
  logic [VW-1:0] r_dvs, r_pr, r_r, w_pr_next;
  logic          r_dbz, w_ge;
  logic [VW:0]   w_trial;
  assign w_trial   = {r_pr, r_dvd[DW-1]};
  assign w_ge      = w_trial >= {1'b0, r_dvs};
  assign w_pr_next = w_ge ? VW'(w_trial - {1'b0, r_dvs}) : w_trial[VW-1:0];
  assign busy      = r_state != IDLE;
  assign done      = r_state == DONE;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign dbz       = r_dbz;
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: zero divisor skips straight to DONE, otherwise DW shift-subtract steps
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = start ? (divisor == '0 ? DONE : CALC) : IDLE;
    else if (r_state == CALC) w_next = r_cnt == CW'(1) ? DONE : CALC;
  end
  // operand capture, shift-subtract datapath and result registers updated on DONE entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_pr  <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_cnt <= CW'(DW);
      r_dvd <= dividend;
      r_dvs <= divisor;
      r_pr  <= '0;
      if (divisor == '0) begin
        r_q   <= '1;
        r_r   <= '0;
        r_dbz <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - CW'(1);
      r_dvd <= {r_dvd[DW-2:0], w_ge};
      r_pr  <= w_pr_next;
      if (r_cnt == CW'(1)) begin
        r_q   <= {r_dvd[DW-2:0], w_ge};
        r_r   <= w_pr_next;
        r_dbz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_restore_div.sv
// tb_restore_div: scoreboard bench for the restoring divider
module tb_restore_div;
  localparam int DW = 8;
  localparam int VW = 4;
  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
  } exp_t;
  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, dbz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  int            checks = 0, errors = 0;
  exp_t          sb[$];
  restore_div #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = '0;
      e.dbz = 1'b1;
    end else begin
      e.q = a / DW'(b);
      e.r = VW'(a % DW'(b));
      e.dbz = 1'b0;
    end
    return e;
  endfunction
  task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    dividend = DW'($urandom);
    divisor = VW'($urandom);
  endtask
  task automatic wait_done(output bit ok, output int lat, output int nb);
    lat = 1;
    nb = 0;
    while (!done && lat < 40) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
    nb += int'(busy);
    ok = done;
  endtask
  task automatic test_reset;
    start = 1'b1;
    dividend = 8'd81;
    divisor = 4'd9;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0", busy, done, quotient, remainder, dbz);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask
  task automatic test_basic;
    bit ok;
    int lat, nb;
    exp_t e;
    logic [DW-1:0] a[4] = '{8'd81, 8'd80, 8'd7, 8'd255};
    logic [VW-1:0] b[4] = '{4'd9, 4'd9, 4'd9, 4'd1};
    for (int i = 0; i < 4; i++) begin
      launch(a[i], b[i]);
      wait_done(ok, lat, nb);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != DW + 1 || nb != DW + 1) begin
        errors++;
        $display("FAIL basic_timing %0d/%0d done=%0b latency=%0d busy_cycles=%0d required 1 %0d %0d", a[i], b[i], ok, lat, nb, DW + 1, DW + 1);
      end
      checks++;
      if (quotient !== e.q || remainder !== e.r || dbz !== e.dbz) begin
        errors++;
        $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b", a[i], b[i], quotient, remainder, dbz, e.q, e.r, e.dbz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_pulse done=%0b busy=%0b required 0 0", done, busy);
      end
    end
  endtask
  task automatic test_dbz;
    bit ok;
    int lat, nb;
    exp_t e;
    launch(8'd42, 4'd0);
    wait_done(ok, lat, nb);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 1 || quotient !== 8'd255 || remainder !== 4'd0 || dbz !== 1'b1 || quotient !== e.q) begin
      errors++;
      $display("FAIL dbz done=%0b latency=%0d q=%0d r=%0d dbz=%0b required 1 1 255 0 1", ok, lat, quotient, remainder, dbz);
    end
    launch(8'd10, 4'd3);
    wait_done(ok, lat, nb);
    e = sb.pop_front();
    checks++;
    if (!ok || quotient !== 8'd3 || remainder !== 4'd1 || dbz !== 1'b0 || remainder !== e.r) begin
      errors++;
      $display("FAIL after_dbz done=%0b q=%0d r=%0d dbz=%0b required 1 3 1 0", ok, quotient, remainder, dbz);
    end
  endtask
  task automatic test_back_to_back;
    bit ok;
    int lat, nb;
    exp_t e;
    launch(8'd81, 4'd9);
    repeat (2) @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, lat, nb);
    start = 1'b1;
    e = sb.pop_front();
    checks++;
    if (!ok || quotient !== e.q || remainder !== e.r || dbz !== e.dbz) begin
      errors++;
      $display("FAIL ignore_start done=%0b q=%0d r=%0d required 1 %0d %0d", ok, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_start busy=%0b done=%0b required 0 0", busy, done);
    end
    sb.push_back(model(8'd50, 4'd5));
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, lat, nb);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != DW + 1 || quotient !== 8'd10 || remainder !== 4'd0 || quotient !== e.q) begin
      errors++;
      $display("FAIL accept_k_plus_dw_plus_2 done=%0b latency=%0d q=%0d r=%0d required 1 %0d 10 0", ok, lat, quotient, remainder, DW + 1);
    end
  endtask
  task automatic test_reset_abort;
    bit ok;
    int lat, nb, dones;
    exp_t e;
    launch(8'd81, 4'd9);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0", busy, done, quotient, remainder, dbz);
    end
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      dones += int'(done);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done done_pulses=%0d required 0", dones);
    end
    launch(8'd64, 4'd8);
    wait_done(ok, lat, nb);
    e = sb.pop_front();
    checks++;
    if (!ok || quotient !== 8'd8 || remainder !== 4'd0 || quotient !== e.q) begin
      errors++;
      $display("FAIL after_abort done=%0b q=%0d r=%0d required 1 8 0", ok, quotient, remainder);
    end
  endtask
  task automatic test_sweep;
    bit ok;
    int lat, nb;
    exp_t e;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(DW'(a), VW'(b));
        wait_done(ok, lat, nb);
        e = sb.pop_front();
        checks++;
        if (!ok || quotient !== e.q || remainder !== e.r || dbz !== e.dbz) begin
          errors++;
          if (errors < 20) $display("FAIL sweep %0d/%0d done=%0b got q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b", a, b, ok, quotient, remainder, dbz, e.q, e.r, e.dbz);
        end
      end
    end
  endtask
  task automatic test_arraymul;
    bit ok;
    int lat, nb;
    exp_t e;
    for (int a = 1; a <= 9; a++) begin
      for (int b = 1; b <= 9; b++) begin
        launch(DW'(a * b), VW'(b));
        wait_done(ok, lat, nb);
        e = sb.pop_front();
        checks++;
        if (!ok || quotient !== DW'(a) || remainder !== '0 || dbz !== 1'b0 || quotient !== e.q) begin
          errors++;
          $display("FAIL arraymul %0d*%0d/%0d done=%0b got q=%0d r=%0d required q=%0d r=0", a, b, b, ok, quotient, remainder, a);
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_dbz;
    test_back_to_back;
    test_reset_abort;
    test_sweep;
    test_arraymul;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
